// File: rtl/clkgate_pkg.sv
// rtl/clkgate_pkg.sv - shared state encoding and default constants for the clock-gate controller
package clkgate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } state_e;

  localparam int DEF_WAKE_CYC = 2;
  localparam int DEF_IDLE_CYC = 8;
  localparam int STATS_W      = 32;

endpackage

// File: rtl/clkgate_ctrl_if.sv
// rtl/clkgate_ctrl_if.sv - requester handshake and gate-enable bundle between requesters and the controller
interface clkgate_ctrl_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            force_on;
  logic            gate;
  logic            busy;

  modport master (
    output req,
    output force_on,
    input  ack,
    input  gate,
    input  busy
  );

  modport slave (
    input  req,
    input  force_on,
    output ack,
    output gate,
    output busy
  );

endinterface

// File: rtl/clkgate_ctrl_sat_cnt.sv
// rtl/clkgate_ctrl_sat_cnt.sv - saturating up-counter with synchronous clear (clear beats increment)
module clkgate_ctrl_sat_cnt
  import clkgate_pkg::*;
#(
  parameter int W = STATS_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/clkgate_ctrl.sv
// rtl/clkgate_ctrl.sv - clock-gate enable controller: wake settle, idle hysteresis, per-requester ack
// Optional CLKGATE_CTRL_STATS_EN adds stats_clr / off_cycles (cycles spent gated off).
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int IDLE_CYC = DEF_IDLE_CYC,
  parameter int CW       = 8
) (
  input logic           clk,
  input logic           rst_n,
  clkgate_ctrl_if.slave bus
`ifdef CLKGATE_CTRL_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [STATS_W-1:0] off_cycles
`endif
);

  localparam int WW = 4;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [WW-1:0]   r_wake_cnt;
  logic [WW-1:0]   w_wake_nxt;
  logic [CW-1:0]   r_idle_cnt;
  logic [CW-1:0]   w_idle_nxt;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] w_ack_nxt;
  logic            r_gate;
  logic            r_busy;
  logic            w_any_req;

  // force_on wakes the domain like a requester but never earns an ack
  assign w_any_req = (|bus.req) | bus.force_on;

  always_comb begin
    w_state_nxt = r_state;
    w_wake_nxt  = r_wake_cnt;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      OFF: begin
        if (w_any_req) begin
          w_state_nxt = WAKE;
          w_wake_nxt  = WW'(WAKE_CYC - 1);
        end
      end
      WAKE: begin
        if (r_wake_cnt == '0) begin
          w_state_nxt = ON;
        end else begin
          w_wake_nxt = r_wake_cnt - 1'b1;
        end
      end
      ON: begin
        if (!w_any_req) begin
          w_state_nxt = IDLE;
          w_idle_nxt  = CW'(IDLE_CYC - 1);
        end
      end
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ON;
        end else if (r_idle_cnt == '0) begin
          w_state_nxt = OFF;
        end else begin
          w_idle_nxt = r_idle_cnt - 1'b1;
        end
      end
      default: w_state_nxt = OFF;
    endcase
    w_ack_nxt = (w_state_nxt == ON) ? bus.req : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OFF;
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_ack      <= '0;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_ack      <= w_ack_nxt;
      r_gate     <= (w_state_nxt != OFF);
      r_busy     <= (w_state_nxt != OFF);
    end
  end

  assign bus.ack  = r_ack;
  assign bus.gate = r_gate;
  assign bus.busy = r_busy;

`ifdef CLKGATE_CTRL_STATS_EN
  clkgate_ctrl_sat_cnt #(
    .W (STATS_W)
  ) u_off_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (stats_clr),
    .i_inc (~r_gate),
    .o_cnt (off_cycles)
  );
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb/tb_clkgate_ctrl.sv - self-checking bench for clkgate_ctrl against a timestamp-based behaviour model
module tb_clkgate_ctrl;

  localparam int NREQ     = 4;
  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clkgate_ctrl_if #(.NREQ(NREQ)) bus ();

`ifdef CLKGATE_CTRL_STATS_EN
  logic        stats_clr;
  logic [31:0] off_cycles;
  logic        sc_clr;
  logic        sc_inc;
  logic [2:0]  sc_cnt;

  clkgate_ctrl_sat_cnt #(.W(3)) u_small_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (sc_clr),
    .i_inc (sc_inc),
    .o_cnt (sc_cnt)
  );
`endif

  clkgate_ctrl #(
    .NREQ     (NREQ),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC),
    .CW       (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CLKGATE_CTRL_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .off_cycles (off_cycles)
`endif
  );

  int n_pass;
  int n_chk;

  // model: gate level, edges since gate rose, consecutive idle edges after settling
  bit              m_gate;
  int              m_age;
  int              m_idle;
  logic [NREQ-1:0] m_ack;

  int lat;
  int hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_gate = 1'b0;
    m_age  = 0;
    m_idle = 0;
    m_ack  = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] rq, input bit fo);
    bit any;
    any = (|rq) | fo;
    if (!m_gate) begin
      m_ack = '0;
      if (any) begin
        m_gate = 1'b1;
        m_age  = 0;
        m_idle = 0;
      end
    end else begin
      m_age++;
      if (m_age < WAKE_CYC) begin
        m_ack = '0;
      end else if (m_age == WAKE_CYC || any) begin
        m_ack  = rq;
        m_idle = 0;
      end else begin
        m_ack = '0;
        m_idle++;
        if (m_idle > IDLE_CYC) m_gate = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] rq;
    bit              fo;
    bit              rs;
    rq = bus.req;
    fo = bus.force_on;
    rs = rst_n;
    @(posedge clk);
    if (rs) model_edge(rq, fo);
    else    model_reset();
    #1;
    chk("gate", {31'd0, bus.gate}, {31'd0, m_gate});
    chk("busy", {31'd0, bus.busy}, {31'd0, m_gate});
    chk("ack",  32'(bus.ack),      32'(m_ack));
  endtask

  initial begin
    n_pass       = 0;
    n_chk        = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.force_on = 1'b0;
`ifdef CLKGATE_CTRL_STATS_EN
    stats_clr = 1'b0;
    sc_clr    = 1'b0;
    sc_inc    = 1'b0;
`endif
    model_reset();

    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    // cold wake: req rise to ack must take WAKE_CYC+1 cycles
    bus.req = 4'b0001;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.ack[0] && lat < 20);
    chk("cold_lat", 32'(lat), 32'(WAKE_CYC + 1));
    repeat (15) step();

    // idle hysteresis: gate must hold IDLE_CYC cycles past the ON->IDLE edge
    bus.req = '0;
    step();
    chk("ack_drop", {31'd0, bus.ack[0]}, 32'd0);
    hold = 1;
    while (bus.gate && hold < 40) begin
      step();
      hold++;
    end
    chk("idle_hold", 32'(hold), 32'(IDLE_CYC + 1));

    // warm re-request mid-idle
    bus.req = 4'b0001;
    lat = 0;
    while (!bus.ack[0] && lat < 20) begin
      step();
      lat++;
    end
    chk("rewake_lat", 32'(lat), 32'(WAKE_CYC + 1));
    bus.req = '0;
    repeat (3) step();
    bus.req = 4'b0100;
    step();
    chk("warm_ack", {31'd0, bus.ack[2]}, 32'd1);
    chk("warm_gate", {31'd0, bus.gate}, 32'd1);
    repeat (4) step();
    bus.req = '0;
    repeat (3) step();

    // force_on keeps the clock without acking; async reset drops gate at once
    bus.force_on = 1'b1;
    repeat (10) step();
    chk("force_gate", {31'd0, bus.gate}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_gate", {31'd0, bus.gate}, 32'd0);
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_rewake", {31'd0, bus.gate}, 32'd1);
    bus.force_on = 1'b0;

    // random traffic with quiet stretches so gating off and warm wakes both occur
    for (int c = 0; c < 2000; c++) begin
      if ((c % 100) < 60) begin
        if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom);
        bus.force_on = ($urandom_range(0, 15) == 0);
      end else begin
        bus.req      = '0;
        bus.force_on = 1'b0;
        if ($urandom_range(0, 19) == 0) bus.req[$urandom_range(0, NREQ - 1)] = 1'b1;
      end
      step();
    end
    bus.req      = '0;
    bus.force_on = 1'b0;

`ifdef CLKGATE_CTRL_STATS_EN
    hold = 0;
    while (bus.gate && hold < 40) begin
      step();
      hold++;
    end
    chk("stats_off_wait", {31'd0, bus.gate}, 32'd0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr", off_cycles, 32'd0);
    repeat (50) step();
    chk("stats_50", off_cycles, 32'd50);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr2", off_cycles, 32'd0);
    sc_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", 32'(sc_cnt), 32'd7);
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_clr", 32'(sc_cnt), 32'd0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
